logic_gate_stream: RTL and testbench

//  Parametrised, registered bitwise gate unit; successor to the single-bit combinational gate labs.

---
 rtl/logic_gate_pkg.sv | 44 ++++
 rtl/gate_bitwise.sv | 21 ++
 rtl/logic_gate_stream.sv | 128 ++++++++++++
 tb/tb_logic_gate_stream.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// Shared op codes, FSM states and per-bit gate helpers for the gate stream unit.
package logic_gate_pkg;

    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_OR     = 3'b001;
    localparam logic [2:0] OP_XOR    = 3'b010;
    localparam logic [2:0] OP_NAND   = 3'b011;
    localparam logic [2:0] OP_NOR    = 3'b100;
    localparam logic [2:0] OP_XNOR   = 3'b101;
    localparam logic [2:0] OP_PASS_A = 3'b110;
    localparam logic [2:0] OP_NOT_A  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    // Non-inverted family of a gate: AND/OR/XOR, or pass-through of x.
    function automatic logic gate_base(input logic [2:0] op, input logic x, input logic y);
        case (op)
            OP_AND, OP_NAND: gate_base = x & y;
            OP_OR,  OP_NOR:  gate_base = x | y;
            OP_XOR, OP_XNOR: gate_base = x ^ y;
            default:         gate_base = x;
        endcase
    endfunction

    // Gates whose final result is the complement of their base family.
    function automatic logic op_inverts(input logic [2:0] op);
        op_inverts = (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR) || (op == OP_NOT_A);
    endfunction

    // Map any op onto its non-inverting base code.
    function automatic logic [2:0] op_base(input logic [2:0] op);
        case (op)
            OP_NAND:  op_base = OP_AND;
            OP_NOR:   op_base = OP_OR;
            OP_XNOR:  op_base = OP_XOR;
            OP_NOT_A: op_base = OP_PASS_A;
            default:  op_base = op;
        endcase
    endfunction

endpackage

// File: rtl/gate_bitwise.sv
// Combinational WIDTH-bit gate: f = op(x, y), applied independently per bit.
module gate_bitwise
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] f
);

    // Per-bit gate evaluation; no carries between bits.
    always_comb begin
        f = '0;
        for (int i = 0; i < WIDTH; i++) begin
            f[i] = gate_base(op, x[i], y[i]) ^ op_inverts(op);
        end
    end

endmodule

// File: rtl/logic_gate_stream.sv
// Registered valid/ready gate unit with optional DEPTH-beat accumulate mode.
module logic_gate_stream
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_last
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [2:0]       op_q, op_d;
    logic             mode_q, mode_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             out_last_q, out_last_d;

    logic             accept;
    logic [2:0]       cur_op, base_op;
    logic             cur_mode;
    logic [WIDTH-1:0] beat_base, comb_x, comb_f, acc_next;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign out_last  = out_last_q;

    // Burst regs own op/mode once a burst is open; otherwise the live inputs apply.
    always_comb begin
        cur_op   = (state_q == ST_ACC) ? op_q   : op;
        cur_mode = (state_q == ST_ACC) ? mode_q : acc_mode;
        base_op  = op_base(cur_op);
        // First beat combines with the family identity so one datapath serves every beat.
        if (base_op == OP_PASS_A)
            comb_x = beat_base;
        else if (state_q == ST_ACC)
            comb_x = acc_q;
        else if (base_op == OP_AND)
            comb_x = '1;
        else
            comb_x = '0;
        acc_next = comb_f ^ {WIDTH{op_inverts(cur_op)}};
    end

    gate_bitwise #(.WIDTH(WIDTH)) u_beat (
        .op (base_op),
        .x  (a),
        .y  (b),
        .f  (beat_base)
    );

    gate_bitwise #(.WIDTH(WIDTH)) u_comb (
        .op (cur_op),
        .x  (comb_x),
        .y  (beat_base),
        .f  (comb_f)
    );

    // Next-state: FSM, beat counter, accumulator and 1-entry output register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        op_d        = op_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q && !out_ready;
        y_d         = y_q;
        out_last_d  = out_last_q;
        if (accept) begin
            if (!cur_mode || (DEPTH == 1) ||
                ((state_q == ST_ACC) && (cnt_q == CW'(DEPTH - 1)))) begin
                y_d         = comb_f;
                out_valid_d = 1'b1;
                out_last_d  = 1'b1;
                cnt_d       = '0;
                state_d     = ST_IDLE;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (state_q == ST_IDLE) begin
                    op_d    = op;
                    mode_d  = acc_mode;
                    state_d = ST_ACC;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            op_q        <= OP_AND;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_logic_gate_stream.sv
// Directed bench for logic_gate_stream (WIDTH=4, DEPTH=4).
module tb_logic_gate_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a, b;
    logic [2:0] op;
    logic       acc_mode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y;
    logic       out_last;

    int total = 0;
    int bad   = 0;

    logic_gate_stream #(.WIDTH(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_mode  (acc_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] ia, input logic [3:0] ib, input logic [2:0] iop);
        in_valid = 1'b1;
        a = ia;
        b = ib;
        op = iop;
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; a = 4'hF; b = 4'hF; op = 3'b000;
        acc_mode = 1'b0; out_ready = 1'b1;

        // 1. reset with in_valid asserted
        tick(); tick();
        chk("rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_y", {4'd0, y}, 8'd0);
        chk("rst_last", {7'd0, out_last}, 8'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("rst_ready", {7'd0, in_ready}, 8'd1);
        chk("rst_idle_valid", {7'd0, out_valid}, 8'd0);

        // 2. single beats, one result per cycle
        beat(4'b1100, 4'b1010, 3'b000);
        chk("and_y", {4'd0, y}, 8'b1000);
        chk("and_valid", {7'd0, out_valid}, 8'd1);
        chk("and_last", {7'd0, out_last}, 8'd1);
        beat(4'b1100, 4'b1010, 3'b001);
        chk("or_y", {4'd0, y}, 8'b1110);
        chk("or_ready", {7'd0, in_ready}, 8'd1);
        beat(4'b1100, 4'b1010, 3'b010);
        chk("xor_y", {4'd0, y}, 8'b0110);
        beat(4'b1100, 4'b1010, 3'b100);
        chk("nor_y", {4'd0, y}, 8'b0001);
        chk("nor_valid", {7'd0, out_valid}, 8'd1);
        beat(4'b1100, 4'b1010, 3'b111);
        chk("not_y", {4'd0, y}, 8'b0011);
        in_valid = 1'b0;
        tick();
        chk("single_drain", {7'd0, out_valid}, 8'd0);

        // 3. accumulate OR; op change mid-burst ignored
        acc_mode = 1'b1;
        beat(4'b0001, 4'b0000, 3'b001);
        chk("accor_b1", {7'd0, out_valid}, 8'd0);
        beat(4'b0010, 4'b0000, 3'b000);
        chk("accor_b2", {7'd0, out_valid}, 8'd0);
        beat(4'b0100, 4'b0000, 3'b000);
        chk("accor_b3", {7'd0, out_valid}, 8'd0);
        beat(4'b1000, 4'b0000, 3'b000);
        chk("accor_valid", {7'd0, out_valid}, 8'd1);
        chk("accor_y", {4'd0, y}, 8'b1111);
        chk("accor_last", {7'd0, out_last}, 8'd1);
        in_valid = 1'b0;
        tick();
        chk("accor_drain", {7'd0, out_valid}, 8'd0);

        // 4. accumulate NAND
        repeat (3) beat(4'b1111, 4'b1111, 3'b011);
        chk("nand_b3", {7'd0, out_valid}, 8'd0);
        beat(4'b1111, 4'b1111, 3'b011);
        chk("nand_valid", {7'd0, out_valid}, 8'd1);
        chk("nand_y", {4'd0, y}, 8'b0000);
        beat(4'b1111, 4'b1111, 3'b011);
        chk("nand2_b1", {7'd0, out_valid}, 8'd0);
        beat(4'b1111, 4'b0111, 3'b011);
        beat(4'b1111, 4'b1111, 3'b011);
        beat(4'b1111, 4'b1111, 3'b011);
        chk("nand2_y", {4'd0, y}, 8'b1000);
        chk("nand2_valid", {7'd0, out_valid}, 8'd1);
        in_valid = 1'b0;
        tick();

        // 5. backpressure
        acc_mode = 1'b0; out_ready = 1'b0;
        beat(4'b1100, 4'b0101, 3'b010);
        chk("bp_first_y", {4'd0, y}, 8'b1001);
        a = 4'b0011; b = 4'b0000; op = 3'b001;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_low", {7'd0, in_ready}, 8'd0);
            chk("bp_y_hold", {4'd0, y}, 8'b1001);
            chk("bp_valid_hold", {7'd0, out_valid}, 8'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_back", {7'd0, in_ready}, 8'd1);
        tick();
        chk("bp_second_y", {4'd0, y}, 8'b0011);
        chk("bp_second_valid", {7'd0, out_valid}, 8'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_no_dup", {7'd0, out_valid}, 8'd0);

        // 6. reset mid-burst discards partial accumulation
        acc_mode = 1'b1;
        beat(4'b1111, 4'b0000, 3'b010);
        beat(4'b1000, 4'b0000, 3'b010);
        in_valid = 1'b0; rst = 1'b1;
        tick();
        chk("midrst_valid", {7'd0, out_valid}, 8'd0);
        rst = 1'b0;
        beat(4'b0001, 4'b0000, 3'b010);
        beat(4'b0010, 4'b0000, 3'b010);
        beat(4'b0100, 4'b0000, 3'b010);
        chk("midrst_b3", {7'd0, out_valid}, 8'd0);
        beat(4'b0000, 4'b0000, 3'b010);
        chk("midrst_valid_end", {7'd0, out_valid}, 8'd1);
        chk("midrst_y", {4'd0, y}, 8'b0111);
        in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
